onewire_txn_sequencer: RTL and testbench

- Transaction-level controller for the 1-wire bus.
- Sequences a bit-level 1-wire PHY, which owns the line timing, through one full transaction: bus reset/presence, ROM command byte, function command byte, then N data-byte reads.
- Retries reset on missing presence; optionally checks a Dallas CRC-8 over the received bytes.
- Sits between the host/CSR logic and the bit-level master.

---
 rtl/onewire_txn_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_onewire_txn_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_txn_sequencer.sv
// onewire_txn_sequencer
// Transaction-level 1-wire controller. Sequences a bit-level PHY through
// bus reset/presence (with retries), ROM command byte, function command byte
// and N data-byte reads, returning each received byte with a one-cycle pulse.
// Optional feature macro: ONEWIRE_CRC_EN enables a Dallas CRC-8 residue check
// over the received bytes (err = 2'b10 on a non-zero residue).
//
// PHY handshake (valid/ready style): phy_req is the valid, phy_ack the ready.
// phy_req rises with phy_op already stable; both hold until the cycle in
// which phy_ack is sampled high, and that cycle completes the operation.
// phy_req is then low for at least one cycle before the next operation.
// phy_ack seen while phy_req is low carries no meaning and is ignored.

module onewire_txn_sequencer #(
  parameter int MAX_RETRY = 3,
  parameter int MAX_BYTES = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rom_cmd,
  input  logic [7:0] func_cmd,
  input  logic [3:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       phy_req,
  output logic [1:0] phy_op,
  input  logic       phy_ack,
  input  logic       phy_rbit,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_ROM  = 3'd2,
    S_FUNC = 3'd3,
    S_READ = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [7:0] rom_q;
  logic [7:0] func_q;
  logic [7:0] shreg_q;
  logic [3:0] len_q;
  logic [3:0] byte_cnt_q;
  logic [3:0] retry_cnt_q;
  logic [2:0] bit_cnt_q;

  logic       accept;
  logic       ack_ok;
  logic       op_state;
  logic       last_bit;
  logic       last_byte;
  logic       retry_left;
  logic [7:0] byte_in;
  logic [1:0] op_d;
  logic [3:0] len_clamped;

  assign accept      = (state_q == S_IDLE) && start;
  assign ack_ok      = phy_req && phy_ack;
  assign op_state    = (state_q == S_RST) || (state_q == S_ROM) ||
                       (state_q == S_FUNC) || (state_q == S_READ);
  assign last_bit    = (bit_cnt_q == 3'd7);
  assign last_byte   = (byte_cnt_q == (len_q - 4'd1));
  assign retry_left  = (retry_cnt_q < 4'(MAX_RETRY));
  assign byte_in     = {phy_rbit, shreg_q[7:1]};
  assign len_clamped = (rd_len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : rd_len;

  assign busy      = op_state;
  assign done      = (state_q == S_FIN);
  assign dbg_state = state_q;
  assign phy_op    = phy_req ? op_d : 2'b00;

`ifdef ONEWIRE_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Reflected CRC-8 (x^8+x^5+x^4+1) advanced by the bit currently on phy_rbit
  always_comb begin
    crc_d = {1'b0, crc_q[7:1]};
    if (crc_q[0] ^ phy_rbit) begin
      crc_d = crc_d ^ 8'h8C;
    end
  end

  // CRC register: cleared on start, updated on every read-slot completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= 8'h00;
    end else if (accept) begin
      crc_q <= 8'h00;
    end else if (ack_ok && (state_q == S_READ)) begin
      crc_q <= crc_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each bus phase advances only on a completed PHY op
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (ack_ok) begin
          if (!phy_rbit) begin
            state_d = S_ROM;
          end else if (!retry_left) begin
            state_d = S_FIN;
          end
        end
      end
      S_ROM: begin
        if (ack_ok && last_bit) begin
          state_d = S_FUNC;
        end
      end
      S_FUNC: begin
        if (ack_ok && last_bit) begin
          state_d = (len_q != 4'd0) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        if (ack_ok && last_bit && last_byte) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operation code for the current phase; write ops send commands LSB first
  always_comb begin
    op_d = 2'b00;
    case (state_q)
      S_ROM:   op_d = rom_q[bit_cnt_q] ? 2'b10 : 2'b01;
      S_FUNC:  op_d = func_q[bit_cnt_q] ? 2'b10 : 2'b01;
      S_READ:  op_d = 2'b11;
      default: op_d = 2'b00;
    endcase
  end

  // Request flag: dropped on the ack cycle, raised again the cycle after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phy_req <= 1'b0;
    end else if (ack_ok) begin
      phy_req <= 1'b0;
    end else if (op_state && !phy_req) begin
      phy_req <= 1'b1;
    end
  end

  // Command and length capture at transaction start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_q  <= 8'h00;
      func_q <= 8'h00;
      len_q  <= 4'd0;
    end else if (accept) begin
      rom_q  <= rom_cmd;
      func_q <= func_cmd;
      len_q  <= len_clamped;
    end
  end

  // Bit, byte and retry counters; bit counter wraps 7->0 at byte boundaries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 4'd0;
      retry_cnt_q <= 4'd0;
    end else if (accept) begin
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 4'd0;
      retry_cnt_q <= 4'd0;
    end else if (ack_ok) begin
      case (state_q)
        S_RST: begin
          if (phy_rbit && retry_left) begin
            retry_cnt_q <= retry_cnt_q + 4'd1;
          end
        end
        S_ROM, S_FUNC: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        S_READ: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (last_bit) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
          end
        end
        default: begin
          bit_cnt_q <= bit_cnt_q;
        end
      endcase
    end
  end

  // Read shift register and byte delivery, one cycle after the 8th read ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q  <= 8'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (ack_ok && (state_q == S_READ)) begin
        shreg_q <= byte_in;
        if (last_bit) begin
          rd_data  <= byte_in;
          rd_valid <= 1'b1;
        end
      end
    end
  end

  // Error code: set on the transition into FIN so it is valid with done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 2'b00;
    end else if (accept) begin
      err <= 2'b00;
    end else if (ack_ok && (state_q == S_RST) && phy_rbit && !retry_left) begin
      err <= 2'b01;
`ifdef ONEWIRE_CRC_EN
    end else if (ack_ok && (state_q == S_READ) && last_bit && last_byte &&
                 (crc_d != 8'h00)) begin
      err <= 2'b10;
`endif
    end
  end

endmodule

// File: tb/tb_onewire_txn_sequencer.sv
// tb_onewire_txn_sequencer
// Bench for onewire_txn_sequencer: a behavioural PHY responder with random
// ack latency, and a transaction-level reference model that derives the
// expected op stream, received bytes and error code from the commands,
// length, presence pattern and slave data.

module tb_onewire_txn_sequencer;

  localparam int MAX_RETRY = 3;
  localparam int MAX_BYTES = 9;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] rom_cmd;
  logic [7:0] func_cmd;
  logic [3:0] rd_len;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       phy_req;
  logic [1:0] phy_op;
  logic       phy_ack;
  logic       phy_rbit;
  logic [2:0] dbg_state;

  int checks;
  int errors;

  // Slave-side data and bookkeeping
  logic [7:0] data_q[$];
  logic       rbit_q[$];
  logic [1:0] op_log[$];
  int         fails_left;
  int         delay_left;
  logic [1:0] held_op;

  // Reference model outputs
  logic [1:0] exp_ops[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [1:0] exp_err;

  onewire_txn_sequencer #(
    .MAX_RETRY(MAX_RETRY),
    .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rom_cmd  (rom_cmd),
    .func_cmd (func_cmd),
    .rd_len   (rd_len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .phy_req  (phy_req),
    .phy_op   (phy_op),
    .phy_ack  (phy_ack),
    .phy_rbit (phy_rbit),
    .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural PHY: acks each request after 0..2 extra cycles
  initial begin
    phy_ack    = 1'b0;
    phy_rbit   = 1'b0;
    delay_left = -1;
    held_op    = 2'b00;
    forever begin
      @(negedge clk);
      if (phy_ack) begin
        phy_ack = 1'b0;
      end else if (!reset && phy_req) begin
        if (delay_left < 0) begin
          delay_left = $urandom_range(0, 2);
          held_op    = phy_op;
        end
        if (delay_left == 0) begin
          checks++;
          if (phy_op !== held_op) begin
            errors++;
            $display("FAIL phy_op_stable: got %b, held %b", phy_op, held_op);
          end
          op_log.push_back(phy_op);
          if (phy_op == 2'b00) begin
            if (fails_left > 0) begin
              fails_left--;
              phy_rbit = 1'b1;
            end else begin
              phy_rbit = 1'b0;
            end
          end else if (phy_op == 2'b11 && rbit_q.size() > 0) begin
            phy_rbit = rbit_q.pop_front();
          end else begin
            phy_rbit = 1'($urandom_range(0, 1));
          end
          phy_ack    = 1'b1;
          delay_left = -1;
        end else begin
          delay_left--;
        end
      end else begin
        delay_left = -1;
      end
    end
  end

  // Dallas CRC-8 over the first n bytes of data_q
  function automatic logic [7:0] crc8_of(input int n);
    logic [7:0] c;
    logic [7:0] d;
    logic       fb;
    c = 8'h00;
    for (int b = 0; b < n; b++) begin
      d = data_q[b];
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ d[i];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  // Reference model: expected op stream, bytes and error for one transaction
  task automatic model_txn(input logic [7:0] rom, input logic [7:0] func,
                           input int len, input int fails);
    int n;
    exp_ops.delete();
    exp_q.delete();
    n = (len > MAX_BYTES) ? MAX_BYTES : len;
    if (fails > MAX_RETRY) begin
      for (int i = 0; i <= MAX_RETRY; i++) exp_ops.push_back(2'b00);
      exp_err = 2'b01;
      return;
    end
    for (int i = 0; i <= fails; i++) exp_ops.push_back(2'b00);
    for (int i = 0; i < 8; i++) exp_ops.push_back(rom[i] ? 2'b10 : 2'b01);
    for (int i = 0; i < 8; i++) exp_ops.push_back(func[i] ? 2'b10 : 2'b01);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) exp_ops.push_back(2'b11);
      exp_q.push_back(data_q[b]);
    end
    exp_err = 2'b00;
`ifdef ONEWIRE_CRC_EN
    if (n > 0 && crc8_of(n) != 8'h00) exp_err = 2'b10;
`endif
  endtask

  // Drive start for one cycle from a negedge
  task automatic drive_start(input logic [7:0] rom, input logic [7:0] func,
                             input logic [3:0] len);
    @(negedge clk);
    start    = 1'b1;
    rom_cmd  = rom;
    func_cmd = func;
    rd_len   = len;
    @(negedge clk);
    start    = 1'b0;
    rom_cmd  = $urandom_range(0, 255);
    func_cmd = $urandom_range(0, 255);
    rd_len   = $urandom_range(0, 15);
  endtask

  // Run one transaction and compare against the reference model
  task automatic do_txn(input string tag, input logic [7:0] rom,
                        input logic [7:0] func, input logic [3:0] len,
                        input int fails, input bit noise);
    bit         seen;
    logic [1:0] got_err;
    int         bad;
    model_txn(rom, func, int'(len), fails);
    op_log.delete();
    got_q.delete();
    rbit_q.delete();
    fails_left = fails;
    foreach (data_q[b]) begin
      for (int i = 0; i < 8; i++) rbit_q.push_back(data_q[b][i]);
    end
    drive_start(rom, func, len);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b, want 1", tag, busy);
    end
    seen    = 1'b0;
    got_err = 2'b00;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (rd_valid) got_q.push_back(rd_data);
      if (done) begin
        seen    = 1'b1;
        got_err = err;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_with_done: got %b, want 0", tag, busy);
        end
        break;
      end
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        rom_cmd  = $urandom_range(0, 255);
        func_cmd = $urandom_range(0, 255);
        rd_len   = $urandom_range(0, 15);
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 5000 cycles", tag);
      return;
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b, want %b", tag, got_err, exp_err);
    end
    checks++;
    if (op_log.size() != exp_ops.size()) begin
      errors++;
      $display("FAIL %s op_count: got %0d, want %0d", tag, op_log.size(), exp_ops.size());
    end else begin
      bad = -1;
      foreach (exp_ops[i]) if (bad < 0 && op_log[i] !== exp_ops[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s op_seq[%0d]: got %b, want %b", tag, bad, op_log[bad], exp_ops[bad]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s rd_count: got %0d, want %0d", tag, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s rd_data[%0d]: got %h, want %h", tag, i, got_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b err=%b, want 0 0 %b",
               tag, done, busy, err, exp_err);
    end
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    rom_cmd = 8'h00;
    func_cmd = 8'h00;
    rd_len = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, rd_data, rd_valid, phy_req, phy_op, dbg_state} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rd_data=%h rd_valid=%b phy_req=%b phy_op=%b state=%0d, want all 0",
               busy, done, err, rd_data, rd_valid, phy_req, phy_op, dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || phy_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: busy=%b phy_req=%b, want 0 0", busy, phy_req);
    end
  endtask

  task automatic test_read_rom();
    data_q = '{8'h28, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00};
    data_q.push_back(crc8_of(7));
    do_txn("read_rom", 8'h33, 8'h00, 4'd8, 0, 1'b0);
  endtask

  task automatic test_no_presence();
    fill_random(2);
    do_txn("no_presence", 8'h33, 8'hBE, 4'd2, 100, 1'b0);
  endtask

  task automatic test_retry();
    fill_random(3);
    do_txn("retry_ok", 8'hCC, 8'hBE, 4'd3, 2, 1'b0);
    fill_random(1);
    do_txn("retry_edge", 8'hCC, 8'hBE, 4'd1, MAX_RETRY, 1'b0);
  endtask

  task automatic test_write_only();
    data_q.delete();
    do_txn("write_only", 8'hCC, 8'h44, 4'd0, 0, 1'b0);
  endtask

  task automatic test_crc_corrupt();
    data_q = '{8'h28, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00};
    data_q.push_back(crc8_of(7) ^ 8'h01);
    do_txn("crc_corrupt", 8'h33, 8'h00, 4'd8, 0, 1'b0);
  endtask

  task automatic test_clamp();
    fill_random(MAX_BYTES);
    data_q[MAX_BYTES-1] = crc8_of(MAX_BYTES - 1);
    do_txn("clamp", 8'h55, 8'hAA, 4'd15, 0, 1'b0);
  endtask

  task automatic test_abort();
    bit reached;
    fill_random(3);
    op_log.delete();
    rbit_q.delete();
    fails_left = 0;
    drive_start(8'h55, 8'hF0, 4'd3);
    reached = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (op_log.size() >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL abort_reach: only %0d ops before budget, want 5", op_log.size());
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (phy_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: phy_req=%b busy=%b done=%b, want 0 0 0", phy_req, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || phy_req !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: done=%b phy_req=%b, want 0 0", done, phy_req);
      end
    end
    fill_random(4);
    data_q[3] = crc8_of(3);
    do_txn("after_abort", 8'h33, 8'h0F, 4'd4, 1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    int f;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 15);
      f = $urandom_range(0, 4);
      fill_random(MAX_BYTES);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        if (n >= MAX_BYTES) data_q[MAX_BYTES-1] = crc8_of(MAX_BYTES - 1);
        else data_q[n-1] = crc8_of(n - 1);
      end
      do_txn($sformatf("random%0d", t), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 4'(n), f, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    data_q.delete();
    do_txn("b2b_a", 8'hCC, 8'h44, 4'd0, 0, 1'b0);
    fill_random(2);
    do_txn("b2b_b", 8'hF0, 8'h0F, 4'd2, 0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fails_left = 0;
    test_reset();
    test_read_rom();
    test_no_presence();
    test_retry();
    test_write_only();
    test_crc_corrupt();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
